// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state encoding, character bounds and sizing helper for the RC4 decrypt stage
package rc4_pkg;
  localparam int DEF_MSG_LEN = 32;
  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;
  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, RD_SI_W, CALC_J, RD_SJ, RD_SJ_W,
    WR_SJ, WR_SI, RD_F, RD_F_W, WR_DEC, DONE
  } state_t;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rc4_decrypt_if.sv
// rc4_decrypt_if: control handshake plus S RAM, ciphertext ROM and plaintext RAM ports
interface rc4_decrypt_if import rc4_pkg::*; #(parameter int MSG_LEN = DEF_MSG_LEN);
  localparam int AW = addr_w(MSG_LEN);
  logic start, finish, msg_ok;
  logic [7:0] s_addr, s_rdata, s_wdata;
  logic s_wren;
  logic [AW-1:0] enc_addr, dec_addr;
  logic [7:0] enc_rdata, dec_wdata;
  logic dec_wren;
  modport master (
    input start, s_rdata, enc_rdata,
    output finish, msg_ok, s_addr, s_wdata, s_wren, enc_addr, dec_addr, dec_wdata, dec_wren
  );
  modport slave (
    output start, s_rdata, enc_rdata,
    input finish, msg_ok, s_addr, s_wdata, s_wren, enc_addr, dec_addr, dec_wdata, dec_wren
  );
endinterface

// File: rtl/rc4_char_check.sv
// rc4_char_check: flags a byte that is a lowercase letter or a space
module rc4_char_check import rc4_pkg::*; (
  input  logic [7:0] ch,
  output logic       valid
);
  assign valid = (ch >= CHAR_LO && ch <= CHAR_HI) || ch == CHAR_SP;
endmodule

// File: rtl/rc4_decrypt.sv
// rc4_decrypt: RC4 PRGA over a pre-shuffled S RAM, XORs keystream with ciphertext and
// reports whether every decrypted byte is printable
module rc4_decrypt import rc4_pkg::*; #(
  parameter int MSG_LEN     = DEF_MSG_LEN,
  parameter bit EARLY_ABORT = 1'b1
) (
  input logic clk,
  input logic reset,
  rc4_decrypt_if.master bus
);
  localparam int AW = addr_w(MSG_LEN);
  localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);
  state_t state;
  logic [7:0] i, j, si, sj, f, e, plain;
  logic [AW-1:0] k;
  logic valid;
  assign plain = f ^ e;
  assign bus.dec_wdata = plain;
  rc4_char_check u_chk (.ch(plain), .valid(valid));
  // outputs are registered, so each transition loads the values the next state presents
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      si <= '0;
      sj <= '0;
      f <= '0;
      e <= '0;
      bus.finish <= 1'b0;
      bus.msg_ok <= 1'b0;
      bus.s_addr <= '0;
      bus.s_wdata <= '0;
      bus.s_wren <= 1'b0;
      bus.enc_addr <= '0;
      bus.dec_addr <= '0;
      bus.dec_wren <= 1'b0;
    end else begin
      bus.finish <= 1'b0;
      bus.s_wren <= 1'b0;
      bus.dec_wren <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          i <= '0;
          j <= '0;
          k <= '0;
          bus.msg_ok <= 1'b1;
          state <= INC_I;
        end
        INC_I: begin
          i <= i + 8'd1;
          bus.s_addr <= i + 8'd1;
          state <= RD_SI;
        end
        RD_SI: state <= RD_SI_W;
        RD_SI_W: begin
          si <= bus.s_rdata;
          state <= CALC_J;
        end
        CALC_J: begin
          j <= j + si;
          bus.s_addr <= j + si;
          state <= RD_SJ;
        end
        RD_SJ: state <= RD_SJ_W;
        RD_SJ_W: begin
          sj <= bus.s_rdata;
          bus.s_wdata <= si;
          bus.s_wren <= 1'b1;
          state <= WR_SJ;
        end
        // when i==j the second write stores the value the first one wrote, leaving S[i] intact
        WR_SJ: begin
          bus.s_addr <= i;
          bus.s_wdata <= sj;
          bus.s_wren <= 1'b1;
          state <= WR_SI;
        end
        WR_SI: begin
          bus.s_addr <= si + sj;
          bus.enc_addr <= k;
          state <= RD_F;
        end
        RD_F: state <= RD_F_W;
        RD_F_W: begin
          f <= bus.s_rdata;
          e <= bus.enc_rdata;
          bus.dec_addr <= k;
          bus.dec_wren <= 1'b1;
          state <= WR_DEC;
        end
        WR_DEC: begin
          if (!valid) bus.msg_ok <= 1'b0;
          if (k == K_LAST || (EARLY_ABORT && !valid)) begin
            bus.finish <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
            state <= INC_I;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rc4_decrypt.sv
// tb_rc4_decrypt: known-answer, corner-case and randomized checks against a software RC4 model
module tb_rc4_decrypt;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rc4_decrypt_if #(.MSG_LEN(10)) bus0 ();
  rc4_decrypt_if #(.MSG_LEN(32)) bus1 ();
  rc4_decrypt #(.MSG_LEN(10), .EARLY_ABORT(1'b0)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  rc4_decrypt #(.MSG_LEN(32), .EARLY_ABORT(1'b1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [7:0] s_mem [2][256];
  logic [7:0] enc_mem [2][32];
  logic [7:0] dec_mem [2][32];
  bit dec_wr [2][32];
  int s_wr_cnt [2];
  int dec_wr_cnt [2];
  int fin_cnt [2];

  always @(posedge clk) begin
    if (bus0.s_wren) begin
      s_mem[0][bus0.s_addr] <= bus0.s_wdata;
      s_wr_cnt[0] <= s_wr_cnt[0] + 1;
    end
    bus0.s_rdata <= s_mem[0][bus0.s_addr];
    bus0.enc_rdata <= enc_mem[0][bus0.enc_addr];
    if (bus0.dec_wren) begin
      dec_mem[0][bus0.dec_addr] <= bus0.dec_wdata;
      dec_wr[0][bus0.dec_addr] <= 1'b1;
      dec_wr_cnt[0] <= dec_wr_cnt[0] + 1;
    end
    if (bus0.finish) fin_cnt[0] <= fin_cnt[0] + 1;
  end

  always @(posedge clk) begin
    if (bus1.s_wren) begin
      s_mem[1][bus1.s_addr] <= bus1.s_wdata;
      s_wr_cnt[1] <= s_wr_cnt[1] + 1;
    end
    bus1.s_rdata <= s_mem[1][bus1.s_addr];
    bus1.enc_rdata <= enc_mem[1][bus1.enc_addr];
    if (bus1.dec_wren) begin
      dec_mem[1][bus1.dec_addr] <= bus1.dec_wdata;
      dec_wr[1][bus1.dec_addr] <= 1'b1;
      dec_wr_cnt[1] <= dec_wr_cnt[1] + 1;
    end
    if (bus1.finish) fin_cnt[1] <= fin_cnt[1] + 1;
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] key [3];
  logic [7:0] ksa_s [256];
  logic [7:0] ref_s [256];
  logic [7:0] w [256];
  logic [7:0] ks [32];
  logic [7:0] pt [32];

  typedef struct { int k; logic [7:0] exp; } kat_t;
  kat_t kat [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit printable(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7a) || b == 8'h20;
  endfunction

  task automatic ksa();
    logic [7:0] j, t;
    for (int n = 0; n < 256; n++) ksa_s[n] = 8'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = j + ksa_s[n] + key[n % 3];
      t = ksa_s[n];
      ksa_s[n] = ksa_s[j];
      ksa_s[j] = t;
    end
  endtask

  // keystream for n bytes from ref_s; commit keeps the permuted S as the new reference
  task automatic gen(input int n, input bit commit);
    logic [7:0] i, j, t;
    w = ref_s;
    i = 0;
    j = 0;
    for (int q = 0; q < n; q++) begin
      i = i + 8'd1;
      j = j + w[i];
      t = w[i];
      w[i] = w[j];
      w[j] = t;
      ks[q] = w[8'(w[i] + w[j])];
    end
    if (commit) ref_s = w;
  endtask

  task automatic load_s(input int u);
    for (int n = 0; n < 256; n++) s_mem[u][n] <= ref_s[n];
  endtask

  task automatic clear(input int u);
    s_wr_cnt[u] <= 0;
    dec_wr_cnt[u] <= 0;
    fin_cnt[u] <= 0;
    for (int t = 0; t < 32; t++) dec_wr[u][t] <= 1'b0;
  endtask

  function automatic int s_mism(input int u);
    int m = 0;
    for (int n = 0; n < 256; n++) if (s_mem[u][n] !== ref_s[n]) m++;
    return m;
  endfunction

  task automatic set_start(input int u, input logic v);
    if (u == 0) bus0.start = v;
    else bus1.start = v;
  endtask

  function automatic logic fin(input int u);
    return u == 0 ? bus0.finish : bus1.finish;
  endfunction

  function automatic logic ok(input int u);
    return u == 0 ? bus0.msg_ok : bus1.msg_ok;
  endfunction

  task automatic run(input int u, output int cyc);
    @(negedge clk);
    set_start(u, 1'b1);
    @(posedge clk);
    #1;
    set_start(u, 1'b0);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!fin(u) && cyc < 2000);
  endtask

  // encrypts pt with the model keystream, runs the DUT and checks everything it should have done
  task automatic do_run(input int u, input int len, input bit ea, input string tag, output int cyc);
    int n, bad;
    bit exp_ok;
    gen(len, 1'b0);
    for (int t = 0; t < len; t++) enc_mem[u][t] <= ks[t] ^ pt[t];
    n = len;
    exp_ok = 1'b1;
    for (int t = 0; t < len; t++)
      if (!printable(pt[t])) begin
        exp_ok = 1'b0;
        if (ea && n == len) n = t + 1;
      end
    clear(u);
    run(u, cyc);
    chk($sformatf("%s cycles", tag), cyc, 11 * n);
    for (int t = 0; t < n; t++) chk($sformatf("%s dec[%0d]", tag, t), dec_mem[u][t], pt[t]);
    bad = 0;
    for (int t = n; t < len; t++) if (dec_wr[u][t]) bad++;
    chk($sformatf("%s unwritten", tag), bad, 0);
    chk($sformatf("%s s_writes", tag), s_wr_cnt[u], 2 * n);
    chk($sformatf("%s dec_writes", tag), dec_wr_cnt[u], n);
    @(posedge clk);
    #1;
    chk($sformatf("%s finish_pulse", tag), fin(u), 0);
    chk($sformatf("%s fin_cnt", tag), fin_cnt[u], 1);
    chk($sformatf("%s msg_ok", tag), ok(u), exp_ok);
    gen(n, 1'b1);
    chk($sformatf("%s s_ram", tag), s_mism(u), 0);
  endtask

  initial begin
    logic [7:0] kv [10];
    logic [7:0] encv [10];
    logic [7:0] p1 [10];
    logic [7:0] p2 [10];
    bit ok1, ok2;
    int cyc;
    kv = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    for (int t = 0; t < 10; t++) kat[t] = '{k: t, exp: kv[t]};
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 256; n++) s_mem[u][n] <= 8'h00;
      for (int t = 0; t < 32; t++) begin
        enc_mem[u][t] <= 8'h00;
        dec_mem[u][t] <= 8'h00;
      end
      clear(u);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst finish0", bus0.finish, 0);
    chk("rst msg_ok0", bus0.msg_ok, 0);
    chk("rst s_wren0", bus0.s_wren, 0);
    chk("rst dec_wren0", bus0.dec_wren, 0);
    chk("rst s_addr0", bus0.s_addr, 0);
    chk("rst enc_addr1", bus1.enc_addr, 0);
    chk("rst dec_addr1", bus1.dec_addr, 0);
    chk("rst dec_wdata1", bus1.dec_wdata, 0);
    @(negedge clk);
    reset = 1'b0;

    key = '{8'h4B, 8'h65, 8'h79};
    ksa();

    ref_s = ksa_s;
    load_s(0);
    gen(10, 1'b0);
    for (int t = 0; t < 10; t++) pt[t] = ks[t];
    do_run(0, 10, 1'b0, "kat", cyc);
    chk("kat cyc110", cyc, 110);
    for (int t = 0; t < 10; t++) chk($sformatf("kat table[%0d]", t), dec_mem[0][kat[t].k], kat[t].exp);
    chk("kat msg_ok", bus0.msg_ok, 0);

    ref_s = ksa_s;
    load_s(1);
    for (int t = 0; t < 32; t++) pt[t] = 8'h61;
    do_run(1, 32, 1'b1, "all_a", cyc);
    chk("all_a cyc352", cyc, 352);
    chk("all_a msg_ok", bus1.msg_ok, 1);
    chk("all_a last", dec_mem[1][31], 8'h61);

    ref_s = ksa_s;
    load_s(1);
    pt[3] = 8'h41;
    do_run(1, 32, 1'b1, "abort", cyc);
    chk("abort cyc44", cyc, 44);
    chk("abort dec3", dec_mem[1][3], 8'h41);
    chk("abort msg_ok", bus1.msg_ok, 0);

    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
    load_s(0);
    for (int t = 0; t < 10; t++) pt[t] = 8'($urandom);
    do_run(0, 10, 1'b0, "ident", cyc);

    ref_s = ksa_s;
    load_s(0);
    for (int t = 0; t < 10; t++) enc_mem[0][t] <= 8'h00;
    clear(0);
    @(negedge clk);
    set_start(0, 1'b1);
    @(posedge clk);
    #1;
    set_start(0, 1'b0);
    repeat (61) @(posedge clk);
    #1;
    chk("pre_rst s_wren", bus0.s_wren, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst s_wren", bus0.s_wren, 0);
    chk("mid_rst s_addr", bus0.s_addr, 0);
    chk("mid_rst msg_ok", bus0.msg_ok, 0);
    chk("mid_rst dec_wren", bus0.dec_wren, 0);
    chk("mid_rst finish", bus0.finish, 0);
    chk("mid_rst enc_addr", bus0.enc_addr, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    gen(5, 1'b1);
    chk("mid_rst s_ram", s_mism(0), 0);
    chk("mid_rst dec_writes", dec_wr_cnt[0], 5);
    for (int t = 0; t < 10; t++) pt[t] = 8'(8'h61 + $urandom_range(0, 25));
    do_run(0, 10, 1'b0, "after_rst", cyc);

    ref_s = ksa_s;
    load_s(0);
    for (int t = 0; t < 10; t++) begin
      encv[t] = 8'($urandom);
      enc_mem[0][t] <= encv[t];
    end
    gen(10, 1'b0);
    ok1 = 1'b1;
    for (int t = 0; t < 10; t++) begin
      p1[t] = ks[t] ^ encv[t];
      if (!printable(p1[t])) ok1 = 1'b0;
    end
    gen(10, 1'b1);
    gen(10, 1'b0);
    ok2 = 1'b1;
    for (int t = 0; t < 10; t++) begin
      p2[t] = ks[t] ^ encv[t];
      if (!printable(p2[t])) ok2 = 1'b0;
    end
    gen(10, 1'b1);
    clear(0);
    @(negedge clk);
    set_start(0, 1'b1);
    @(posedge clk);
    #1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus0.finish && cyc < 2000);
    chk("held run1 cyc", cyc, 110);
    for (int t = 0; t < 10; t++) chk($sformatf("held run1 dec[%0d]", t), dec_mem[0][t], p1[t]);
    chk("held run1 msg_ok", bus0.msg_ok, ok1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= 5) set_start(0, cyc < 100 ? 1'($urandom_range(0, 1)) : 1'b0);
    end while (!bus0.finish && cyc < 2000);
    chk("held run2 cyc", cyc, 112);
    for (int t = 0; t < 10; t++) chk($sformatf("held run2 dec[%0d]", t), dec_mem[0][t], p2[t]);
    chk("held run2 msg_ok", bus0.msg_ok, ok2);
    set_start(0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("held fin_cnt", fin_cnt[0], 2);
    chk("held s_ram", s_mism(0), 0);

    for (int r = 0; r < 6; r++) begin
      for (int q = 0; q < 3; q++) key[q] = 8'($urandom);
      ksa();
      ref_s = ksa_s;
      load_s(1);
      for (int t = 0; t < 32; t++)
        if ($urandom_range(0, 19) == 0) pt[t] = 8'($urandom);
        else if ($urandom_range(0, 26) == 0) pt[t] = 8'h20;
        else pt[t] = 8'(8'h61 + $urandom_range(0, 25));
      do_run(1, 32, 1'b1, $sformatf("rnd%0d", r), cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
